// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: CPU MEM-stage port, JPEG IP burst port and memory port.
// master is the arbiter's view; slave is the view of everything around it.
interface dmem_arbiter_if #(
  parameter int AW = 20,
  parameter int DW = 32,
  parameter int LW = 8
);
  logic          cpu_req;
  logic          cpu_rw;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;

  logic          ip_req;
  logic          ip_rw;
  logic [AW-1:0] ip_addr;
  logic [LW-1:0] ip_len;
  logic [DW-1:0] ip_wdata;
  logic          ip_gnt;
  logic          ip_beat;
  logic [DW-1:0] ip_rdata;
  logic          ip_rvalid;
  logic          ip_done;

  logic          mem_ena;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    input  ip_req, ip_rw, ip_addr, ip_len, ip_wdata,
    input  mem_rdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    output ip_gnt, ip_beat, ip_rdata, ip_rvalid, ip_done,
    output mem_ena, mem_rw, mem_addr, mem_wdata
  );

  modport slave (
    output cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    output ip_req, ip_rw, ip_addr, ip_len, ip_wdata,
    output mem_rdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    input  ip_gnt, ip_beat, ip_rdata, ip_rvalid, ip_done,
    input  mem_ena, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU single-word accesses vs. JPEG IP bursts, with bounded bursts.
// Define DMEM_ARB_PERF_EN to add saturating stall/beat performance counters.
module dmem_arbiter #(
  parameter int AW        = 20,
  parameter int DW        = 32,
  parameter int LW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.master bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]    perf_cpu_stall,
  output logic [31:0]    perf_ip_beats
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_YIELD = 2'd2;

  localparam int             BCW        = $clog2(MAX_BURST + 1);
  localparam logic [BCW-1:0] BEAT_LIMIT = BCW'(MAX_BURST);

  logic [1:0]     state_reg, state_next;
  logic [AW-1:0]  addr_reg, addr_next;
  logic [LW-1:0]  rem_reg, rem_next;
  logic [BCW-1:0] beats_reg, beats_next;
  logic           yield_reg, yield_next;
  logic           rw_reg;
  logic           rd_cpu_reg, rd_ip_reg;

  logic [LW-1:0]  len_eff;
  logic           issue_cpu, issue_ip, gnt, done;
  logic [AW-1:0]  ip_beat_addr;
  logic           ip_beat_rw;

  assign len_eff = (bus.ip_len == '0) ? LW'(1) : bus.ip_len;

  // Next-state and grant decision; the memory port below is driven straight from this.
  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    rem_next     = rem_reg;
    beats_next   = beats_reg;
    yield_next   = yield_reg;
    issue_cpu    = 1'b0;
    issue_ip     = 1'b0;
    gnt          = 1'b0;
    done         = 1'b0;
    ip_beat_addr = addr_reg;
    ip_beat_rw   = rw_reg;

    case (state_reg)
      ST_IDLE: begin
        // The CPU normally wins, unless it already jumped ahead of a waiting IP request.
        if (bus.ip_req && (!bus.cpu_req || yield_reg)) begin
          gnt          = 1'b1;
          issue_ip     = 1'b1;
          ip_beat_addr = bus.ip_addr;
          ip_beat_rw   = bus.ip_rw;
          yield_next   = 1'b0;
          if (len_eff == LW'(1)) begin
            done = 1'b1;
          end else begin
            state_next = ST_BURST;
            addr_next  = bus.ip_addr + AW'(1);
            rem_next   = len_eff - LW'(1);
            beats_next = BCW'(1);
          end
        end else if (bus.cpu_req) begin
          issue_cpu = 1'b1;
          if (bus.ip_req) begin
            yield_next = 1'b1;
          end
        end
      end

      ST_BURST: begin
        issue_ip  = 1'b1;
        addr_next = addr_reg + AW'(1);
        rem_next  = rem_reg - LW'(1);
        if (beats_reg != BEAT_LIMIT) begin
          beats_next = beats_reg + BCW'(1);
        end
        if (rem_reg == LW'(1)) begin
          done       = 1'b1;
          state_next = ST_IDLE;
          beats_next = '0;
        end else if ((beats_next == BEAT_LIMIT) && bus.cpu_req) begin
          state_next = ST_YIELD;
        end
      end

      ST_YIELD: begin
        issue_cpu  = bus.cpu_req;
        beats_next = '0;
        state_next = ST_BURST;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Everything combinational is forced low while reset is held, so outputs drop immediately.
  always_comb begin
    bus.mem_ena   = 1'b0;
    bus.mem_rw    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.cpu_stall = 1'b0;
    bus.ip_gnt    = 1'b0;
    bus.ip_beat   = 1'b0;
    bus.ip_done   = 1'b0;
    if (!rst) begin
      if (issue_ip) begin
        bus.mem_ena   = 1'b1;
        bus.mem_rw    = ip_beat_rw;
        bus.mem_addr  = ip_beat_addr;
        bus.mem_wdata = bus.ip_wdata;
      end else if (issue_cpu) begin
        bus.mem_ena   = 1'b1;
        bus.mem_rw    = bus.cpu_rw;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
      end
      bus.cpu_stall = bus.cpu_req && !issue_cpu;
      bus.ip_gnt    = gnt;
      bus.ip_beat   = issue_ip;
      bus.ip_done   = done;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      addr_reg   <= '0;
      rem_reg    <= '0;
      beats_reg  <= '0;
      yield_reg  <= 1'b0;
      rw_reg     <= 1'b0;
      rd_cpu_reg <= 1'b0;
      rd_ip_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      rem_reg    <= rem_next;
      beats_reg  <= beats_next;
      yield_reg  <= yield_next;
      if (gnt) begin
        rw_reg <= bus.ip_rw;
      end
      // Owner tag for the read return that arrives next cycle.
      rd_cpu_reg <= issue_cpu && !bus.cpu_rw;
      rd_ip_reg  <= issue_ip && !ip_beat_rw;
    end
  end

  assign bus.cpu_rvalid = rd_cpu_reg;
  assign bus.cpu_rdata  = rd_cpu_reg ? bus.mem_rdata : '0;
  assign bus.ip_rvalid  = rd_ip_reg;
  assign bus.ip_rdata   = rd_ip_reg ? bus.mem_rdata : '0;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cpu_stall <= '0;
      perf_ip_beats  <= '0;
    end else begin
      if (bus.cpu_stall && (perf_cpu_stall != '1)) begin
        perf_cpu_stall <= perf_cpu_stall + 32'd1;
      end
      if (bus.ip_beat && (perf_ip_beats != '1)) begin
        perf_ip_beats <= perf_ip_beats + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a transaction-level schedule model predicts every cycle
// of the memory port and handshakes; a shadow memory predicts all read data.
module tb_dmem_arbiter;
  localparam int AW   = 20;
  localparam int DW   = 32;
  localparam int LW   = 8;
  localparam int MAXB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW), .LW(LW)) bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_cpu_stall, perf_ip_beats;
  dmem_arbiter #(.AW(AW), .DW(DW), .LW(LW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perf_cpu_stall(perf_cpu_stall), .perf_ip_beats(perf_ip_beats));
`else
  dmem_arbiter #(.AW(AW), .DW(DW), .LW(LW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (a == 20'h00010) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  // Memory environment: synchronous single port, read data one cycle after enable.
  logic [DW-1:0] wr_arr [0:(1<<AW)-1];
  bit            wr_vld [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_ena) begin
      if (bus.mem_rw) begin
        wr_arr[bus.mem_addr] <= bus.mem_wdata;
        wr_vld[bus.mem_addr] <= 1'b1;
      end else begin
        bus.mem_rdata <= wr_vld[bus.mem_addr] ? wr_arr[bus.mem_addr] : init_word(bus.mem_addr);
      end
    end
  end

  // Reference shadow memory, updated only from the predicted schedule.
  logic [DW-1:0] ref_mem [int];
  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
  endfunction

  typedef struct packed {
    bit          cpu_req;
    bit          c_rw;
    bit [AW-1:0] c_addr;
    bit [DW-1:0] c_wd;
    bit          ip_req;
    bit [DW-1:0] ip_wd;
    bit          ena;
    bit          rw;
    bit [AW-1:0] addr;
    bit [DW-1:0] wd;
    bit          gnt;
    bit          beat;
    bit          done;
    bit          stall;
  } cyc_t;

  cyc_t sched[$];

  bit          p_irw;
  bit [AW-1:0] p_iaddr;
  bit [LW-1:0] p_ilen;
  bit [DW-1:0] p_wbase;
  bit          c_rw   [2];
  bit [AW-1:0] c_addr [2];
  bit [DW-1:0] c_wd   [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;
  bit          exp_cpu_rv = 1'b0;
  bit          exp_ip_rv  = 1'b0;
  bit [DW-1:0] exp_rd     = '0;

  function automatic bit [DW-1:0] ip_word(input int k);
    return p_wbase ^ (32'h01000193 * k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc_no, obs, exp);
    end
  endtask

  // Builds the expected per-cycle schedule for one IP burst (optional) plus up to two CPU
  // accesses arriving at the given cycles, each held until served. Rules: CPU first in IDLE
  // unless it already jumped a waiting IP; bursts run back to back and let one CPU access
  // through after MAX_BURST consecutive beats if words remain.
  task automatic plan(input bit with_ip, input int ncpu, input int arr0, input int arr1);
    int len, k, consec, ci, cyc, owner;
    bit granted, in_burst, yflag, yield_now, cpu_now;
    int arr[2];
    cyc_t e;
    arr[0] = arr0;
    arr[1] = arr1;
    len = (p_ilen == 0) ? 1 : int'(p_ilen);
    k = 0; consec = 0; ci = 0; cyc = 0;
    granted = !with_ip; in_burst = 1'b0; yflag = 1'b0; yield_now = 1'b0;
    sched.delete();
    while (!(granted && !in_burst && !yield_now && ci == ncpu) && cyc < 400) begin
      e = '0;
      cpu_now = (ci < ncpu) && (cyc >= arr[ci]);
      e.ip_req = !granted;
      if (cpu_now) begin
        e.cpu_req = 1'b1; e.c_rw = c_rw[ci]; e.c_addr = c_addr[ci]; e.c_wd = c_wd[ci];
      end
      owner = -2;
      if (yield_now) begin
        owner = -1; yield_now = 1'b0; consec = 0;
      end else if (in_burst) begin
        owner = k;
      end else if (!granted && (!cpu_now || yflag)) begin
        owner = 0; granted = 1'b1; in_burst = 1'b1; yflag = 1'b0; consec = 0; e.gnt = 1'b1;
      end else if (cpu_now) begin
        owner = -1;
        if (!granted) yflag = 1'b1;
      end
      if (owner >= 0) begin
        k = owner + 1;
        consec++;
        e.beat = 1'b1; e.done = (k == len); e.ena = 1'b1; e.rw = p_irw;
        e.addr = p_iaddr + AW'(owner); e.wd = ip_word(owner); e.ip_wd = e.wd;
        if (k == len) in_burst = 1'b0;
        else if (consec >= MAXB && cpu_now) yield_now = 1'b1;
      end else if (owner == -1) begin
        e.ena = 1'b1; e.rw = c_rw[ci]; e.addr = c_addr[ci]; e.wd = c_wd[ci];
        ci++;
      end
      e.stall = cpu_now && (owner != -1);
      sched.push_back(e);
      cyc++;
    end
    e = '0;
    sched.push_back(e);
  endtask

  // Plays the schedule; entered and left just after a rising edge.
  task automatic run(input int ncyc);
    cyc_t e;
    for (int i = 0; i < ncyc && i < sched.size(); i++) begin
      e = sched[i];
      bus.cpu_req   = e.cpu_req;
      bus.cpu_rw    = e.c_rw;
      bus.cpu_addr  = e.c_addr;
      bus.cpu_wdata = e.c_wd;
      bus.ip_req    = e.ip_req;
      bus.ip_rw     = e.ip_req ? p_irw   : 1'($urandom);
      bus.ip_addr   = e.ip_req ? p_iaddr : AW'($urandom);
      bus.ip_len    = e.ip_req ? p_ilen  : LW'($urandom);
      bus.ip_wdata  = e.ip_wd;
      @(negedge clk);
      chk("mem_ena",    bus.mem_ena,    e.ena);
      chk("mem_rw",     bus.mem_rw,     e.rw);
      chk("mem_addr",   bus.mem_addr,   e.addr);
      chk("mem_wdata",  bus.mem_wdata,  e.wd);
      chk("ip_gnt",     bus.ip_gnt,     e.gnt);
      chk("ip_beat",    bus.ip_beat,    e.beat);
      chk("ip_done",    bus.ip_done,    e.done);
      chk("cpu_stall",  bus.cpu_stall,  e.stall);
      chk("cpu_rvalid", bus.cpu_rvalid, exp_cpu_rv);
      chk("cpu_rdata",  bus.cpu_rdata,  exp_cpu_rv ? exp_rd : '0);
      chk("ip_rvalid",  bus.ip_rvalid,  exp_ip_rv);
      chk("ip_rdata",   bus.ip_rdata,   exp_ip_rv ? exp_rd : '0);
      if (e.ena && e.rw) ref_mem[int'(e.addr)] = e.wd;
      exp_cpu_rv = e.ena && !e.rw && !e.beat;
      exp_ip_rv  = e.ena && !e.rw && e.beat;
      exp_rd     = ref_rd(e.addr);
      if (e.ena)
        $display("[%0d] %s %s addr=%05h data=%08h", cyc_no, e.beat ? "IP " : "CPU",
                 e.rw ? "WR" : "RD", e.addr, e.rw ? e.wd : exp_rd);
      @(posedge clk);
      #1;
      cyc_no++;
    end
  endtask

  task automatic chk_quiet(input string when);
    chk({when, ".mem_ena"},    bus.mem_ena,    1'b0);
    chk({when, ".mem_addr"},   bus.mem_addr,   '0);
    chk({when, ".cpu_stall"},  bus.cpu_stall,  1'b0);
    chk({when, ".cpu_rvalid"}, bus.cpu_rvalid, 1'b0);
    chk({when, ".ip_gnt"},     bus.ip_gnt,     1'b0);
    chk({when, ".ip_beat"},    bus.ip_beat,    1'b0);
    chk({when, ".ip_done"},    bus.ip_done,    1'b0);
    chk({when, ".ip_rvalid"},  bus.ip_rvalid,  1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [AW-1:0] a;
    // Reset with both requesters active: every output must stay low.
    bus.cpu_req = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ip_req = 1'b1; bus.ip_rw = 1'b0; bus.ip_addr = '0; bus.ip_len = 8'd4; bus.ip_wdata = '0;
    #1 chk_quiet("reset");
    repeat (2) @(posedge clk);
    #1;
    bus.cpu_req = 1'b0; bus.ip_req = 1'b0;
    rst = 1'b0;

    $display("CPU read of 0x00010");
    c_rw[0] = 1'b0; c_addr[0] = 20'h00010; c_wd[0] = $urandom;
    plan(0, 1, 0, 0); run(sched.size());

    for (int n = 0; n < 6; n++) begin
      a = AW'($urandom);
      $display("CPU write/read pair at %05h", a);
      c_rw[0] = 1'b1; c_addr[0] = a; c_wd[0] = $urandom;
      c_rw[1] = 1'b0; c_addr[1] = a; c_wd[1] = $urandom;
      plan(0, 2, 0, 0); run(sched.size());
    end

    $display("IP read burst 0x00100 len 4");
    p_irw = 1'b0; p_iaddr = 20'h00100; p_ilen = 8'd4; p_wbase = $urandom;
    plan(1, 0, 0, 0); run(sched.size());

    $display("Simultaneous CPU/IP requests, second CPU access behind the burst");
    p_irw = 1'b0; p_iaddr = AW'($urandom); p_ilen = 8'd4;
    a = AW'($urandom);
    c_rw[0] = 1'b1; c_addr[0] = a; c_wd[0] = $urandom;
    c_rw[1] = 1'b0; c_addr[1] = a; c_wd[1] = $urandom;
    plan(1, 2, 0, 1); run(sched.size());

    $display("IP write burst len 40, CPU read arrives at beat 2");
    p_irw = 1'b1; p_iaddr = AW'($urandom); p_ilen = 8'd40; p_wbase = $urandom;
    c_rw[0] = 1'b0; c_addr[0] = p_iaddr + AW'(1); c_wd[0] = $urandom;
    plan(1, 1, 2, 0); run(sched.size());
    $display("Read back of the 40-word burst");
    p_irw = 1'b0;
    plan(1, 0, 0, 0); run(sched.size());

    $display("Wrapping write/read bursts at 0xFFFFE");
    p_irw = 1'b1; p_iaddr = 20'hFFFFE; p_ilen = 8'd4; p_wbase = $urandom;
    plan(1, 0, 0, 0); run(sched.size());
    p_irw = 1'b0;
    plan(1, 0, 0, 0); run(sched.size());

    $display("Zero-length burst treated as one word");
    p_irw = 1'b1; p_iaddr = AW'($urandom); p_ilen = 8'd0; p_wbase = $urandom;
    plan(1, 0, 0, 0); run(sched.size());

    for (int n = 0; n < 4; n++) begin
      p_irw = 1'($urandom); p_iaddr = AW'($urandom); p_wbase = $urandom;
      p_ilen = LW'($urandom_range(0, 40));
      c_rw[0] = 1'($urandom); c_addr[0] = p_iaddr + AW'($urandom_range(0, 3));
      c_wd[0] = $urandom;
      $display("Random burst rw=%0d addr=%05h len=%0d", p_irw, p_iaddr, p_ilen);
      plan(1, 1, int'($urandom_range(0, 20)), 0); run(sched.size());
    end

    $display("Reset during beat 3 of an 8-word read burst");
    p_irw = 1'b0; p_iaddr = AW'($urandom); p_ilen = 8'd8;
    plan(1, 0, 0, 0); run(3);
    bus.cpu_req = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = AW'($urandom);
    #2 rst = 1'b1;
    #1 chk_quiet("mid_reset");
    @(posedge clk);
    #1 chk_quiet("held_reset");
    bus.cpu_req = 1'b0;
    rst = 1'b0;
    exp_cpu_rv = 1'b0; exp_ip_rv = 1'b0;
    $display("Fresh CPU read after reset");
    c_rw[0] = 1'b0; c_addr[0] = p_iaddr; c_wd[0] = $urandom;
    plan(0, 1, 0, 0); run(sched.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single-port synchronous data memory between two requesters: the CPU pipeline MEM stage, which makes single-word accesses, and the JPEG IP side, which makes multi-word bursts.
- Sits between the EX/MEM pipeline register, the JPEG controller and the data memory.
- Generates burst addresses and stalls the CPU while the IP owns the memory.
- Routes registered read data back to its owner.

Parameters:
- AW, 20, address width
- DW, 32, data width
- LW, 8, burst length field width
- MAX_BURST, 16, maximum IP beats before a forced yield to a pending CPU request

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, held until accepted
- cpu_rw  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  DW  CPU write data
- cpu_stall  out  1  request present but not accepted this cycle
- cpu_rdata  out  DW  read data
- cpu_rvalid  out  1  cpu_rdata valid, one-cycle pulse
- ip_req  in  1  burst request, held until ip_gnt
- ip_rw  in  1  1 = write, 0 = read
- ip_addr  in  AW  burst start address
- ip_len  in  LW  burst word count; 0 is treated as 1
- ip_wdata  in  DW  write data for the current beat
- ip_gnt  out  1  one-cycle pulse when the burst is accepted
- ip_beat  out  1  memory beat issued for the IP this cycle; ip_wdata is consumed in this cycle
- ip_rdata  out  DW  read data
- ip_rvalid  out  1  ip_rdata valid
- ip_done  out  1  one-cycle pulse when the last beat issues
- mem_ena  out  1  memory enable
- mem_rw  out  1  memory direction
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after a read enable

Behaviour:
- Reset values:
  - All outputs 0.
  - State is IDLE.
  - Beat and remaining-word counters are 0.
  - Yield flag is clear.
- Memory port outputs are combinational from the current state and grant decision. Exactly one owner per cycle.
- Read return:
  - Owner tag and read flag are registered at issue.
  - The next cycle drives cpu_rvalid or ip_rvalid, with rdata equal to mem_rdata.
  - Read latency is 1 cycle from issue.
- States:
  - IDLE:
    - cpu_req has priority: issue the CPU access this cycle, cpu_stall = 0, stay in IDLE.
    - Exception: if the yield flag is set and ip_req is pending, the IP wins.
    - Otherwise, if ip_req: pulse ip_gnt, latch addr and len (0 becomes 1), issue beat 0 in the same cycle, go to BURST. A 1-word burst pulses ip_done in that same cycle and stays in IDLE.
  - BURST:
    - One beat per cycle; address increments by 1 per beat (wraps modulo 2^AW).
    - cpu_req in BURST gives cpu_stall = 1.
    - The beat that takes the remaining count to 0 pulses ip_done and returns to IDLE.
    - After MAX_BURST consecutive beats, if cpu_req = 1 and words remain: go to YIELD.
  - YIELD:
    - Issue the CPU access, cpu_stall = 0.
    - Return to BURST next cycle; beat counter cleared, address and count preserved.
- Fairness:
  - Serving the CPU in IDLE while ip_req is pending sets the yield flag.
  - The flag clears when the IP is granted.
  - The IP therefore waits at most one CPU access.
- ip_req is ignored outside IDLE. The burst uses the values latched at grant.
- Reset mid-burst: the burst is abandoned, no ip_done, pending read return discarded.
- The arbiter never issues more than one memory access per cycle. mem_ena = 0 when idle with no request.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- When defined:
  - Adds output perf_cpu_stall[31:0], counting cycles with cpu_stall = 1.
  - Adds output perf_ip_beats[31:0], counting ip_beat cycles.
  - Both are saturating and cleared by rst.
- When not defined: no counters and no such ports. All other behaviour is identical.

Test Plan:
- CPU read only: cpu_req = 1, rw = 0, addr 0x00010, memory word 0xDEADBEEF → mem_ena in the same cycle, cpu_stall = 0, cpu_rvalid with 0xDEADBEEF one cycle later.
- IP read burst, addr 0x00100, len 4, no CPU traffic → ip_gnt and beat 0 in the same cycle, mem_addr 0x100..0x103 on 4 consecutive cycles, ip_done on beat 3, 4 ip_rvalid each lagging its beat by 1.
- Simultaneous cpu_req and ip_req in IDLE → CPU served first, ip_gnt the following cycle, then the next cpu_req stalls until the burst completes.
- IP write burst len 40 with cpu_req asserted at beat 2:
  - cpu_stall runs until the 16th beat, then one CPU access.
  - Burst resumes at address start+16.
  - Total 40 ip_beat pulses, one ip_done.
- Burst addr 0xFFFFE, len 4 → addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- Assert rst mid-burst at beat 3 of 8:
  - All outputs drop to 0 asynchronously, no ip_done.
  - After release, a fresh cpu_req is served immediately.
